// File: rtl/neo_pattern_sequencer.sv
// neo_pattern_sequencer
//   Upstream stage of the NeoPixel strand controller. Each frame it loads every
//   color byte of every pixel through the controller's load handshake, issues
//   one send, then waits FRAME_CYCLES before advancing a rotating "chase"
//   pattern (one lit pixel, one lit color) and starting the next frame.
//
// Ports
//   clock          in   system clock
//   reset          in   asynchronous, active-high reset
//   enable         in   run enable, sampled in IDLE and at end of WAIT
//   ready_to_load  in   controller accepts load_color this cycle
//   ready_to_send  in   controller accepts send_it this cycle
//   pixel_index    out  pixel being loaded (registered)
//   color_index    out  0=green 1=red 2=blue (registered)
//   color_level    out  byte for (pixel_index, color_index) (registered)
//   load_color     out  one-cycle load strobe
//   send_it        out  one-cycle send strobe
//   frame_done     out  one-cycle pulse with send_it
module neo_pattern_sequencer #(
    parameter int          NUM_PIXELS   = 5,
    parameter int          FRAME_CYCLES = 5_000_000,
    parameter logic [7:0]  LEVEL        = 8'h40
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       ready_to_load,
    input  logic       ready_to_send,
    output logic [2:0] pixel_index,
    output logic [1:0] color_index,
    output logic [7:0] color_level,
    output logic       load_color,
    output logic       send_it,
    output logic       frame_done
);

    localparam int PW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int CW = $clog2(FRAME_CYCLES + 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(NUM_PIXELS - 1);
    localparam logic [PW:0]   PIX_NUM  = (PW + 1)'(NUM_PIXELS);
    localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [1:0]    col_q, col_d;
    logic [PW-1:0] off_q, off_d;
    logic [1:0]    hue_q, hue_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    level_q, level_d;
    logic [PW:0]   rot_sum;
    logic          lit;

    // Strobes are qualified by the ready inputs in the same cycle, so a stall
    // never produces a strobe and reset kills them immediately.
    assign load_color  = (state_q == S_LOAD) && ready_to_load;
    assign send_it     = (state_q == S_SEND) && ready_to_send;
    assign frame_done  = send_it;
    assign pixel_index = 3'(pix_q);
    assign color_index = col_q;
    assign color_level = level_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pix_q   <= '0;
            col_q   <= '0;
            off_q   <= '0;
            hue_q   <= '0;
            cnt_q   <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            col_q   <= col_d;
            off_q   <= off_d;
            hue_q   <= hue_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        col_d   = col_q;
        off_d   = off_q;
        hue_d   = hue_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_LOAD;
                    pix_d   = '0;
                    col_d   = '0;
                end
            end
            S_LOAD: begin
                if (ready_to_load) begin
                    if (col_q == 2'd2) begin
                        col_d = '0;
                        if (pix_q == PIX_LAST) begin
                            pix_d   = '0;
                            state_d = S_SEND;
                        end else begin
                            pix_d = pix_q + PW'(1);
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
            end
            S_SEND: begin
                if (ready_to_send) begin
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (off_q == PIX_LAST) begin
                        off_d = '0;
                        hue_d = (hue_q == 2'd2) ? 2'd0 : hue_q + 2'd1;
                    end else begin
                        off_d = off_q + PW'(1);
                    end
                    state_d = enable ? S_LOAD : S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Level is precomputed from next-state values so it is valid in the same
    // cycle the indices are. (pix + off) < 2*NUM_PIXELS, so "mod == 0" reduces
    // to the sum being 0 or exactly NUM_PIXELS.
    always_comb begin
        rot_sum = {1'b0, pix_d} + {1'b0, off_d};
        lit     = ((rot_sum == '0) || (rot_sum == PIX_NUM)) && (col_d == hue_d);
        level_d = ((state_d == S_LOAD) && lit) ? LEVEL : 8'h00;
    end

endmodule

// File: tb/tb_neo_pattern_sequencer.sv
module tb_neo_pattern_sequencer;

    localparam int         NP = 5;
    localparam int         FC = 20;
    localparam logic [7:0] LV = 8'h40;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       ready_to_load;
    logic       ready_to_send;
    logic [2:0] pixel_index;
    logic [1:0] color_index;
    logic [7:0] color_level;
    logic       load_color;
    logic       send_it;
    logic       frame_done;

    neo_pattern_sequencer #(
        .NUM_PIXELS   (NP),
        .FRAME_CYCLES (FC),
        .LEVEL        (LV)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .ready_to_load (ready_to_load),
        .ready_to_send (ready_to_send),
        .pixel_index   (pixel_index),
        .color_index   (color_index),
        .color_level   (color_level),
        .load_color    (load_color),
        .send_it       (send_it),
        .frame_done    (frame_done)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: frames completed since reset and loads seen in
    // the current frame. The pattern is a pure function of the frame count.
    int frames = 0;
    int exp_idx = 0;
    int cyc = 0;
    int loads_total = 0;
    int last_send_cyc = 0;
    int first_cyc = 0;
    bit tight = 1'b0;
    bit rnd_mode = 1'b0;
    int hold = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_level(int f, int p, int c);
        int off;
        int hue;
        off = f % NP;
        hue = (f / NP) % 3;
        return ((((p + off) % NP) == 0) && (c == hue)) ? LV : 8'h00;
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            frames  = 0;
            exp_idx = 0;
        end else begin
            cyc++;
            chk("fdone_eq_send", 32'(frame_done), 32'(send_it));
            chk("load_send_excl", 32'(load_color & send_it), 32'd0);
            if (exp_idx == 3*NP)
                chk("send_first_rdy", 32'(send_it), 32'(ready_to_send));
            if (send_it) begin
                chk("send_rdy", 32'(ready_to_send), 32'd1);
                chk("send_load_cnt", 32'(exp_idx), 32'(3*NP));
                frames++;
                exp_idx = 0;
                last_send_cyc = cyc;
            end
            if (load_color) begin
                chk("load_rdy", 32'(ready_to_load), 32'd1);
                if (exp_idx == 0) begin
                    first_cyc = cyc;
                    if (frames > 0)
                        chk("frame_gap", 32'((cyc - last_send_cyc) >= FC), 32'd1);
                end
                chk("load_pix", 32'(pixel_index), 32'(exp_idx / 3));
                chk("load_col", 32'(color_index), 32'(exp_idx % 3));
                chk("load_lvl", 32'(color_level), 32'(ref_level(frames, exp_idx / 3, exp_idx % 3)));
                exp_idx++;
                loads_total++;
                if (tight && exp_idx == 3*NP)
                    chk("load_span", 32'(cyc - first_cyc), 32'(3*NP - 1));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        if (rnd_mode) begin
            ready_to_load = ($urandom_range(0, 2) != 0);
            if (exp_idx == 3*NP) begin
                if (hold < 50) begin
                    ready_to_send = 1'b0;
                    hold++;
                end else begin
                    ready_to_send = 1'b1;
                end
            end else begin
                hold = 0;
                ready_to_send = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic run_until_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames < target && n < budget) begin
            step();
            n++;
        end
        chk("frames_reached", 32'(frames), 32'(target));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int saved;
        bit found;
        reset = 1'b1;
        enable = 1'b0;
        ready_to_load = 1'b1;
        ready_to_send = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_outputs", 32'({pixel_index, color_index, color_level, load_color, send_it, frame_done}), 32'd0);
        reset = 1'b0;

        // enable low: stays idle
        repeat (10) step();
        chk("idle_no_loads", 32'(loads_total), 32'd0);

        // Free-running frames with both readies high, through hue change
        enable = 1'b1;
        tight = 1'b1;
        run_until_frames(7, 1000);
        tight = 1'b0;

        // Random ready handshakes, send held off 50 cycles after last load
        rnd_mode = 1'b1;
        run_until_frames(10, 4000);
        rnd_mode = 1'b0;
        ready_to_load = 1'b1;
        ready_to_send = 1'b1;

        // Reset in the middle of the 7th load of frame 2
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (frames == 1 && exp_idx == 6 && load_color) found = 1'b1;
        end
        chk("hit_7th_load", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_outputs", 32'({pixel_index, color_index, color_level, load_color, send_it, frame_done}), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_strobe", 32'({load_color, send_it}), 32'd0);
        run_until_frames(1, 300);

        // Drop enable during WAIT, then re-raise: next frame uses offset 1
        enable = 1'b0;
        saved = loads_total;
        repeat (100) step();
        chk("disabled_no_loads", 32'(loads_total), 32'(saved));
        chk("disabled_frames", 32'(frames), 32'd1);
        enable = 1'b1;
        run_until_frames(2, 300);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
